// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the round-robin memory bus arbiter.
// Package name: bus_arb_pkg.
package bus_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    // Read data returned to a master whose transaction was aborted
    localparam logic [DATA_W-1:0] ABORT_DATA    = 32'hDEADBEEF;
    localparam logic [MASK_W-1:0] S_WR_MASK_RST = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [MASK_W-1:0] wr_mask;
        logic [DATA_W-1:0] data;
    } bus_req_t;

    localparam bus_req_t REQ_RST = '{addr: '0, we: 1'b0, wr_mask: S_WR_MASK_RST, data: '0};

    // Busy-cycle counter is at least 8 bits, wider if the limit needs it
    function automatic int unsigned timeout_cnt_w(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        return (w > 8) ? w : 8;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side request/response and slave-side sel/ack bus seen by the arbiter.
// Modport master is the arbiter's view, modport slave is the surrounding system.
interface bus_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2
);
    import bus_arb_pkg::*;

    localparam int unsigned GRANT_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]        m_sel_i;
    logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i;
    logic [NUM_MASTERS-1:0]        m_we_i;
    logic [NUM_MASTERS*MASK_W-1:0] m_wr_mask_i;
    logic [NUM_MASTERS*DATA_W-1:0] m_data_i;
    logic [NUM_MASTERS-1:0]        m_ack_o;
    logic [DATA_W-1:0]             m_data_o;

    logic                          s_sel_o;
    logic [ADDR_W-1:0]             s_addr_o;
    logic                          s_we_o;
    logic [MASK_W-1:0]             s_wr_mask_o;
    logic [DATA_W-1:0]             s_data_o;
    logic [DATA_W-1:0]             s_data_i;
    logic                          s_ack_i;

    logic [GRANT_W-1:0]            grant_o;
    logic                          timeout_o;

    modport master (
        input  m_sel_i, m_addr_i, m_we_i, m_wr_mask_i, m_data_i,
        input  s_data_i, s_ack_i,
        output m_ack_o, m_data_o,
        output s_sel_o, s_addr_o, s_we_o, s_wr_mask_o, s_data_o,
        output grant_o, timeout_o
    );

    modport slave (
        output m_sel_i, m_addr_i, m_we_i, m_wr_mask_i, m_data_i,
        output s_data_i, s_ack_i,
        input  m_ack_o, m_data_o,
        input  s_sel_o, s_addr_o, s_we_o, s_wr_mask_o, s_data_o,
        input  grant_o, timeout_o
    );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin selector: first eligible index after last_grant,
// wrapping modulo N.
module rr_picker #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] last_grant,
    output logic             valid_c,
    output logic [IDX_W-1:0] idx_c
);

    // Scan farthest-to-nearest so the nearest eligible candidate wins
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand    = '0;
        valid_c = 1'b0;
        idx_c   = '0;
        for (int unsigned d = N; d >= 1; d--) begin
            cand = IDX_W'((32'(last_grant) + d) % N);
            if (eligible[cand]) begin
                valid_c = 1'b1;
                idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one sel/ack slave between NUM_MASTERS requesters,
// one transaction in flight. Optional abort-on-timeout under BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic          clk,
    input  logic          reset_n_i,
    bus_arbiter_if.master bus
);

    localparam int unsigned GRANT_W = $clog2(NUM_MASTERS);

    arb_state_t             state;
    logic [GRANT_W-1:0]     last_grant;
    logic [GRANT_W-1:0]     grant_q;
    logic [NUM_MASTERS-1:0] release_q;
    logic [NUM_MASTERS-1:0] eligible_c;
    logic [NUM_MASTERS-1:0] m_ack_q;
    logic [DATA_W-1:0]      m_data_q;
    logic                   s_sel_q;
    bus_req_t               s_req_q;
    bus_req_t               req_arr_c [NUM_MASTERS];
    logic                   pick_valid_c;
    logic [GRANT_W-1:0]     pick_idx_c;

    // Slice the packed master buses into one request per master
    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
        assign req_arr_c[k] = '{
            addr:    bus.m_addr_i[k*ADDR_W +: ADDR_W],
            we:      bus.m_we_i[k],
            wr_mask: bus.m_wr_mask_i[k*MASK_W +: MASK_W],
            data:    bus.m_data_i[k*DATA_W +: DATA_W]
        };
    end

    // A just-served master stays ineligible until it drops sel at least once
    assign eligible_c = bus.m_sel_i & ~release_q;

    rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (GRANT_W)
    ) u_picker (
        .eligible   (eligible_c),
        .last_grant (last_grant),
        .valid_c    (pick_valid_c),
        .idx_c      (pick_idx_c)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = timeout_cnt_w(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt;
    logic            timeout_q;

    assign bus.timeout_o = timeout_q;
`else
    assign bus.timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= IDLE;
            last_grant <= GRANT_W'(NUM_MASTERS - 1);
            grant_q    <= '0;
            release_q  <= '0;
            m_ack_q    <= '0;
            m_data_q   <= '0;
            s_sel_q    <= 1'b0;
            s_req_q    <= REQ_RST;
`ifdef BUS_ARB_TIMEOUT_EN
            to_cnt     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            m_ack_q   <= '0;
            release_q <= release_q & bus.m_sel_i;
`ifdef BUS_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_valid_c) begin
                        s_req_q    <= req_arr_c[pick_idx_c];
                        s_sel_q    <= 1'b1;
                        grant_q    <= pick_idx_c;
                        last_grant <= pick_idx_c;
                        state      <= BUSY;
`ifdef BUS_ARB_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end
                end
                BUSY: begin
                    // A slave ack on the limit cycle still counts as a normal completion
                    if (bus.s_ack_i) begin
                        s_sel_q            <= 1'b0;
                        s_req_q.we         <= 1'b0;
                        m_data_q           <= bus.s_data_i;
                        m_ack_q[grant_q]   <= 1'b1;
                        release_q[grant_q] <= 1'b1;
                        state              <= IDLE;
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        s_sel_q            <= 1'b0;
                        s_req_q.we         <= 1'b0;
                        m_data_q           <= ABORT_DATA;
                        m_ack_q[grant_q]   <= 1'b1;
                        release_q[grant_q] <= 1'b1;
                        timeout_q          <= 1'b1;
                        state              <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_ack_o     = m_ack_q;
    assign bus.m_data_o    = m_data_q;
    assign bus.s_sel_o     = s_sel_q;
    assign bus.s_addr_o    = s_req_q.addr;
    assign bus.s_we_o      = s_req_q.we;
    assign bus.s_wr_mask_o = s_req_q.wr_mask;
    assign bus.s_data_o    = s_req_q.data;
    assign bus.grant_o     = grant_q;

endmodule
